// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction-fetch front end: credit-limited in-order requests to instruction memory,
// a small return FIFO toward decode, and flush/drop handling on control-flow redirect.
module lc3_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [15:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [15:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [15:0] instr_pc,
  input  logic        redirect,
  input  logic [15:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [15:0] fetch_pc;
  cnt_t        outstanding, outstanding_next;
  cnt_t        drop, drop_next;
  cnt_t        count, count_next;
  ptr_t        wr_ptr, rd_ptr;
  ptr_t        tag_wr, tag_rd;
  logic [CW:0] in_use;

  logic [15:0] tag_mem   [DEPTH];
  logic [15:0] fifo_data [DEPTH];
  logic [15:0] fifo_pc   [DEPTH];

  logic accept, push, pop;

  // Requests are only issued while buffered words plus in-flight requests leave room,
  // so every response is guaranteed a FIFO slot.
  always_comb begin
    in_use        = {1'b0, count} + {1'b0, outstanding};
    mem_req_valid = ~reset & ~redirect & (in_use < (CW+1)'(DEPTH));
  end

  assign accept = mem_req_valid & mem_req_ready;
  assign push   = mem_rsp_valid & (drop == '0) & ~redirect;
  assign pop    = instr_valid & instr_ready & ~redirect;

  assign mem_req_addr = fetch_pc;
  assign instr_valid  = (count != '0);
  assign instruction  = instr_valid ? fifo_data[rd_ptr] : 16'h0000;
  assign instr_pc     = instr_valid ? fifo_pc[rd_ptr]   : 16'h0000;

  // NOTE: every variable assigned in an always_comb gets a value on every path (defaults
  // first), otherwise synthesis infers a latch.
  always_comb begin
    outstanding_next = outstanding + cnt_t'(accept) - cnt_t'(mem_rsp_valid);
    drop_next        = drop;
    count_next       = count + cnt_t'(push) - cnt_t'(pop);
    if (redirect) begin
      // Everything still in flight after this cycle belongs to the abandoned path.
      drop_next  = outstanding_next;
      count_next = '0;
    end else if (mem_rsp_valid && drop != '0) begin
      drop_next = drop - cnt_t'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the
  // same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      assert (!(push && count == cnt_t'(DEPTH)));
      if (redirect)    fetch_pc <= redirect_pc;
      else if (accept) fetch_pc <= fetch_pc + 16'd1;
      outstanding <= outstanding_next;
      drop        <= drop_next;
      count       <= count_next;
      if (accept)        tag_wr <= tag_wr + ptr_t'(1);
      if (mem_rsp_valid) tag_rd <= tag_rd + ptr_t'(1);
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + ptr_t'(1);
        if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      end
    end
  end

  // NOTE: storage arrays are deliberately not reset; count/pointers define which entries
  // are meaningful, and the head outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_data[wr_ptr] <= mem_rsp_data;
      fifo_pc[wr_ptr]   <= tag_mem[tag_rd] + 16'd1;
    end
  end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Self-checking bench for lc3_fetch_unit: a behavioural instruction memory plus a scoreboard
// of expected {word, pc} pairs pushed on request acceptance and compared on each decode pop.
module tb_lc3_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [15:0] mem_rsp_data = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instruction;
  logic [15:0] instr_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;

  always #5 clk = ~clk;

  lc3_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  typedef struct { logic [15:0] data; logic [15:0] pc; } exp_t;
  typedef struct { logic [15:0] addr; int ready_at; } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [15:0] exp_addr = RESET_PC;
  int          checks = 0, failures = 0;
  int          cyc = 0, rsp_delay = 1, accepts = 0, pops = 0, wrap_hits = 0;
  bit          rand_mode = 1'b0;

  function automatic logic [15:0] mem_word(logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive_rsp();
    if (pend_q.size() > 0 && pend_q[0].ready_at <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_q[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'hDEAD;
    end
  endtask

  // One clock: sample at negedge, update memory/scoreboard models, then drive the next cycle.
  task automatic cycle();
    logic acc, pp;
    int   dly;
    exp_t e;
    @(negedge clk);
    acc = mem_req_valid & mem_req_ready;
    pp  = instr_valid & instr_ready & ~redirect;
    if (redirect) check("no_req_on_redirect", 32'(mem_req_valid), 32'd0);
    if (mem_req_valid) check("req_addr", 32'(mem_req_addr), 32'(exp_addr));
    check("inflight_bound", 32'(pend_q.size() <= DEPTH), 32'd1);
    if (pp) begin
      check("instr_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("instr_word", 32'(instruction), 32'(e.data));
        check("instr_pc", 32'(instr_pc), 32'(e.pc));
        if (e.pc == 16'h0000) wrap_hits++;
      end
      pops++;
    end
    if (mem_rsp_valid) void'(pend_q.pop_front());
    if (redirect) begin
      exp_q.delete();
      exp_addr = redirect_pc;
    end
    if (acc) begin
      dly = rand_mode ? int'($urandom_range(1, 5)) : rsp_delay;
      pend_q.push_back('{mem_req_addr, cyc + dly});
      exp_q.push_back('{mem_word(exp_addr), exp_addr + 16'd1});
      exp_addr = exp_addr + 16'd1;
      accepts++;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_rsp();
    if (rand_mode) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready   = ($urandom_range(0, 2) != 0);
      redirect      = ($urandom_range(0, 29) == 0);
      redirect_pc   = 16'($urandom_range(0, 65535));
    end
  endtask

  initial begin
    int  p0;
    bit  found;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_req_addr", 32'(mem_req_addr), 32'(RESET_PC));
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Decode stalled: exactly DEPTH requests, head held
    reset         = 1'b0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b0;
    drive_rsp();
    repeat (15) cycle();
    check("stall_accepts", 32'(accepts), 32'(DEPTH));
    check("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check("stall_instr_valid", 32'(instr_valid), 32'd1);
    check("stall_head_word", 32'(instruction), 32'(mem_word(16'h3000)));
    check("stall_head_pc", 32'(instr_pc), 32'h3001);
    cycle();
    check("stall_head_word_held", 32'(instruction), 32'(mem_word(16'h3000)));

    // Resume: steady one instruction per cycle
    instr_ready = 1'b1;
    repeat (6) cycle();
    p0 = pops;
    repeat (10) cycle();
    check("throughput", 32'(pops - p0), 32'd10);

    // Two requests in flight, redirect to 4000
    mem_req_ready = 1'b0;
    repeat (8) cycle();
    check("drained_instr_valid", 32'(instr_valid), 32'd0);
    rsp_delay     = 4;
    mem_req_ready = 1'b1;
    repeat (2) cycle();
    mem_req_ready = 1'b0;
    check("two_in_flight", 32'(pend_q.size()), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 16'h4000;
    cycle();
    redirect = 1'b0;
    check("redir_addr", 32'(mem_req_addr), 32'h4000);
    mem_req_ready = 1'b1;
    rsp_delay     = 1;
    p0 = pops;
    repeat (12) cycle();
    check("redir_delivered", 32'(pops > p0), 32'd1);

    // Redirect in the same cycle as a response and a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_rsp_valid && instr_valid) found = 1'b1;
      else cycle();
    end
    check("t4_setup_found", 32'(found), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h5000;
    instr_ready = 1'b1;
    cycle();
    redirect = 1'b0;
    check("t4_fifo_empty", 32'(instr_valid), 32'd0);
    check("t4_next_addr", 32'(mem_req_addr), 32'h5000);
    repeat (8) cycle();

    // Address wrap FFFF -> 0000
    redirect    = 1'b1;
    redirect_pc = 16'hFFFF;
    cycle();
    redirect = 1'b0;
    repeat (10) cycle();
    check("wrap_seen", 32'(wrap_hits > 0), 32'd1);

    // Random ready/latency/redirect traffic against the model
    rand_mode = 1'b1;
    repeat (400) cycle();
    rand_mode     = 1'b0;
    redirect      = 1'b0;
    mem_req_ready = 1'b0;
    instr_ready   = 1'b1;
    repeat (30) cycle();
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("final_mem_idle", 32'(pend_q.size()), 32'd0);
    check("final_instr_valid", 32'(instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
